// File: rtl/qam16_ofdm_sequencer.sv
// Frames packet bytes into QAM16-mapped OFDM symbols: null at k=0, pilots every PILOT_SPACING,
// data nibbles (high first) through an external one-cycle mapper, padding after the packet end.
module qam16_ofdm_sequencer #(
  parameter int          NSC           = 64,
  parameter int          PILOT_SPACING = 8,
  parameter logic [15:0] PILOT_VAL     = 16'h0101,
  parameter logic [3:0]  PAD_NIBBLE    = 4'b1101
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [3:0]  map_din,
  output logic        map_wren,
  input  logic [15:0] map_dout,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic        m_eop,
  output logic        busy
);

  localparam int KW = $clog2(NSC);
  localparam int PW = $clog2(PILOT_SPACING);

  typedef enum logic [1:0] {IDLE, RUN, PAD} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
    logic        eop;
  } word_t;

  state_t          state, next_state;
  logic [KW-1:0]   k;
  logic [3:0]      nib_buf;
  logic            nib_valid;
  logic            eop_seen;
  logic            inflight;
  logic            infl_last;
  logic            infl_eop;

  word_t           fifo_mem [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      fifo_count;

  logic            is_null, is_pilot, is_data, last_k;
  logic            pop, wr_en, slot_free;
  logic [1:0]      occ;
  logic            issue, ctl_issue, take_buf, accept, tag_eop;
  word_t           wr_word;

  assign is_null  = (k == '0);
  assign is_pilot = !is_null && (k[PW-1:0] == '0);
  assign is_data  = !is_null && !is_pilot;
  assign last_k   = (k == KW'(NSC - 1));

  assign m_valid  = (fifo_count != 2'd0);
  assign pop      = m_valid && m_ready;
  // Occupancy after this cycle's pop, counting the word still inside the mapper.
  assign occ       = fifo_count - {1'b0, pop} + {1'b0, inflight};
  assign slot_free = (occ < 2'd2);

  assign m_data = fifo_mem[rd_ptr].data;
  assign m_last = fifo_mem[rd_ptr].last;
  assign m_eop  = fifo_mem[rd_ptr].eop;
  assign busy   = (state != IDLE) || m_valid || inflight;

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    ctl_issue  = 1'b0;
    take_buf   = 1'b0;
    accept     = 1'b0;
    map_wren   = 1'b0;
    map_din    = 4'd0;
    s_ready    = 1'b0;
    tag_eop    = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) next_state = RUN;
      end
      RUN, PAD: begin
        if (slot_free) begin
          if (!is_data) begin
            // Null/pilot bypasses the mapper, so it must wait for the mapper to drain.
            if (!inflight) begin
              issue     = 1'b1;
              ctl_issue = 1'b1;
            end
          end else if (nib_valid) begin
            issue    = 1'b1;
            map_wren = 1'b1;
            map_din  = nib_buf;
            take_buf = 1'b1;
          end else if (eop_seen) begin
            issue    = 1'b1;
            map_wren = 1'b1;
            map_din  = PAD_NIBBLE;
          end else if (state == RUN) begin
            s_ready = 1'b1;
            if (s_valid) begin
              accept   = 1'b1;
              issue    = 1'b1;
              map_wren = 1'b1;
              map_din  = s_data[7:4];
            end
          end
        end
        tag_eop = issue && last_k && eop_seen;
        if (tag_eop)
          next_state = IDLE;
        else if (state == RUN && eop_seen && !nib_valid)
          next_state = PAD;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wr_en   = inflight || ctl_issue;
    wr_word = '0;
    if (inflight) begin
      wr_word.data = map_dout;
      wr_word.last = infl_last;
      wr_word.eop  = infl_eop;
    end else begin
      wr_word.data = is_null ? 16'h0000 : PILOT_VAL;
      wr_word.last = last_k;
      wr_word.eop  = tag_eop;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      nib_buf   <= 4'd0;
      nib_valid <= 1'b0;
      eop_seen  <= 1'b0;
      inflight  <= 1'b0;
      infl_last <= 1'b0;
      infl_eop  <= 1'b0;
    end else begin
      state     <= next_state;
      inflight  <= map_wren;
      infl_last <= last_k;
      infl_eop  <= tag_eop;
      if (state == IDLE)
        k <= '0;
      else if (issue)
        k <= last_k ? '0 : k + KW'(1);
      if (accept) begin
        nib_buf   <= s_data[3:0];
        nib_valid <= 1'b1;
      end else if (take_buf) begin
        nib_valid <= 1'b0;
      end
      if (accept && s_last)
        eop_seen <= 1'b1;
      else if (tag_eop)
        eop_seen <= 1'b0;
    end
  end

  // NOTE: the two FIFO entries drive m_data directly, so they are reset to keep
  // every output at zero while rst is held; larger storage would not be reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (wr_en) begin
        fifo_mem[wr_ptr] <= wr_word;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule
